// File: rtl/adder_pkg.sv
// Shared definitions for the wide add/subtract sequencer family.
//   SLICE_W   : width of one adder slice (one operand word)
//   state_e   : controller states
//   signed_ovf: two's-complement overflow from the MSBs of a, b (as presented
//               to the adder, i.e. after any inversion) and the sum
package adder_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add16_slice.sv
// 16-bit combinational carry-lookahead adder slice.
//   a, b : 16-bit addends
//   cin  : carry in
//   sum  : 16-bit sum
//   cout : carry out of bit 15
// Four 4-bit lookahead groups; group carries come from a second lookahead
// level over the group generate/propagate terms, so cin reaches every group
// directly rather than rippling through the lower groups.
module add16_slice
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  // Carries c[0..4] of a 4-wide lookahead unit (c[0] = ci).
  function automatic logic [4:0] cla4(input logic [3:0] g,
                                      input logic [3:0] p,
                                      input logic       ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [SLICE_W-1:0] g_bit;
  logic [SLICE_W-1:0] p_bit;
  logic [3:0]         g_grp;
  logic [3:0]         p_grp;
  logic [4:0]         c_grp;
  logic [4:0]         c_loc;

  always_comb begin
    g_bit = a & b;
    p_bit = a ^ b;
    for (int unsigned i = 0; i < 4; i++) begin
      g_grp[i] = g_bit[4*i+3] | (p_bit[4*i+3] & g_bit[4*i+2])
               | (p_bit[4*i+3] & p_bit[4*i+2] & g_bit[4*i+1])
               | (p_bit[4*i+3] & p_bit[4*i+2] & p_bit[4*i+1] & g_bit[4*i]);
      p_grp[i] = &p_bit[4*i +: 4];
    end
    c_grp = cla4(g_grp, p_grp, cin);
    sum   = '0;
    c_loc = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c_loc          = cla4(g_bit[4*i +: 4], p_bit[4*i +: 4], c_grp[i]);
      sum[4*i +: 4]  = p_bit[4*i +: 4] ^ c_loc[3:0];
    end
    cout = c_grp[4];
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS x 16-bit add/subtract performed one word per cycle, LSW first, on a
// single add16_slice with the carry registered between words.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : request handshake; in_sub selects A-B
//   in_a, in_b           : W-bit operands, sampled on the accept edge only
//   out_valid/out_ready  : result handshake
//   out_sum/cout/ovf     : result, carry out (1 = no borrow on subtract),
//                          signed overflow
//   busy                 : high in CALC or DONE
module wide_add_sequencer
  import adder_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [16*WORDS-1:0]    in_a,
  input  logic [16*WORDS-1:0]    in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*WORDS-1:0]    out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int unsigned W     = SLICE_W * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               sub_q, sub_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] a_w, b_w, s_w;
  logic               s_cout;

  add16_slice u_slice (
    .a    (a_w),
    .b    (b_w),
    .cin  (carry_q),
    .sum  (s_w),
    .cout (s_cout)
  );

  always_comb begin
    a_w = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
    b_w = b_q[SLICE_W*int'(idx_q) +: SLICE_W] ^ {SLICE_W{sub_q}};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          idx_d   = '0;
          carry_d = in_sub;  // +1 of the two's-complement negate of B
          sum_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[SLICE_W*int'(idx_q) +: SLICE_W] = s_w;
        carry_d = s_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = s_cout;
          ovf_d   = signed_ovf(a_w[SLICE_W-1], b_w[SLICE_W-1], s_w[SLICE_W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sub = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one request, verify exact latency and result, then consume it.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf);
    @(negedge clk);
    check({tag, ".in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    @(posedge clk); #1;
    // scramble inputs after the accept edge; they must not matter
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_sub = ~sub;
    check({tag, ".busy"}, W'(busy), W'(1));
    for (int e = 1; e <= int'(WORDS); e++) begin
      @(posedge clk); #1;
      if (e == int'(WORDS) - 1) check({tag, ".early_valid"}, W'(out_valid), W'(0));
    end
    check({tag, ".valid"}, W'(out_valid), W'(1));
    check({tag, ".sum"},   out_sum,        exp_sum);
    check({tag, ".cout"},  W'(out_cout),   W'(exp_cout));
    check({tag, ".ovf"},   W'(out_ovf),    W'(exp_ovf));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".valid_drop"}, W'(out_valid), W'(0));
    check({tag, ".sum_kept"},   out_sum,        exp_sum);
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    #1;
    check("rst.in_ready",  W'(in_ready),  W'(1));
    check("rst.out_valid", W'(out_valid), W'(0));
    check("rst.busy",      W'(busy),      W'(0));
    check("rst.sum",       out_sum,       '0);
    check("rst.cout",      W'(out_cout),  W'(0));
    check("rst.ovf",       W'(out_ovf),   W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("word_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    do_op("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    do_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    do_op("sub_borrow", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    do_op("sub_noborrow", 64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0);
    do_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
          64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Backpressure: result held while a new request waits.
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'h7; in_b = 64'h5; in_sub = 1'b1;
    @(posedge clk); #1;
    in_a = 64'h1; in_b = 64'h2; in_sub = 1'b0;  // next request, held pending
    repeat (WORDS) @(posedge clk);
    #1;
    check("bp.valid", W'(out_valid), W'(1));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp.hold_sum",   out_sum,       64'h2);
      check("bp.hold_valid", W'(out_valid), W'(1));
      check("bp.in_ready",   W'(in_ready),  W'(0));
      check("bp.hold_cout",  W'(out_cout),  W'(1));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_valid", W'(out_valid), W'(0));
    check("bp.release_idle",  W'(in_ready),  W'(1));
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp.accept_busy", W'(busy), W'(1));
    in_valid = 1'b0;
    repeat (WORDS) @(posedge clk);
    #1;
    check("bp.next_valid", W'(out_valid), W'(1));
    check("bp.next_sum",   out_sum,       64'h3);
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Asynchronous reset in the middle of CALC (idx == 2).
    @(negedge clk);
    in_valid = 1'b1; in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", W'(out_valid), W'(0));
    check("arst.busy",      W'(busy),      W'(0));
    check("arst.in_ready",  W'(in_ready),  W'(1));
    check("arst.sum",       out_sum,       '0);
    @(negedge clk); rst_n = 1'b1;
    do_op("post_rst", 64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
